// File: rtl/i2s_decoder_pkg.sv
// i2s_decoder_pkg: shared I2S channel codes and default sample width
package i2s_decoder_pkg;
  localparam int DEF_SAMPLE_BITS = 16;
  localparam logic I2S_CH_LEFT = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_decoder_if.sv
// i2s_decoder_if: I2S pins toward the receiver plus the recovered PCM pair
interface i2s_decoder_if import i2s_decoder_pkg::*; #(parameter int SAMPLE_BITS = DEF_SAMPLE_BITS);
  logic lrclk_i, bclk_i, dacdat_i;
  logic [SAMPLE_BITS-1:0] l_chan_o, r_chan_o;
  logic valid_o, err_o;
  modport master (output lrclk_i, bclk_i, dacdat_i, input l_chan_o, r_chan_o, valid_o, err_o);
  modport slave (input lrclk_i, bclk_i, dacdat_i, output l_chan_o, r_chan_o, valid_o, err_o);
endinterface

// File: rtl/cdc_sync2.sv
// cdc_sync2: two-flop synchronizer for a single asynchronous level
module cdc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // shift the async input through two flops to settle metastability
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/i2s_decoder.sv
// i2s_decoder: slave I2S receiver recovering 16-bit stereo PCM from oversampled pins
module i2s_decoder import i2s_decoder_pkg::*; #(parameter int SAMPLE_BITS = DEF_SAMPLE_BITS) (
  input logic clk,
  input logic rst,
  i2s_decoder_if.slave bus
);
  localparam int CW = $clog2(SAMPLE_BITS + 1);
  logic lr_s, bclk_s, dat_s, bclk_prev;
  logic [1:0] ev_p, lr_p, dat_p;
  logic lr_prev, armed, hold_ok;
  logic [SAMPLE_BITS-1:0] shift, hold;
  logic [CW-1:0] cnt;
  logic full;
  assign full = cnt == CW'(SAMPLE_BITS);
  cdc_sync2 u_lr (.clk(clk), .rst(rst), .d(bus.lrclk_i), .q(lr_s));
  cdc_sync2 u_bclk (.clk(clk), .rst(rst), .d(bus.bclk_i), .q(bclk_s));
  cdc_sync2 u_dat (.clk(clk), .rst(rst), .d(bus.dacdat_i), .q(dat_s));
  // detect bclk rises and carry lrck/data alongside them so all three stay aligned
  always_ff @(posedge clk or posedge rst)
    if (rst) {bclk_prev, ev_p, lr_p, dat_p} <= '0;
    else begin
      bclk_prev <= bclk_s;
      ev_p <= {ev_p[0], bclk_s & ~bclk_prev};
      lr_p <= {lr_p[0], lr_s};
      dat_p <= {dat_p[0], dat_s};
    end
  // framing on each bit event: delay slot finishes the old word, otherwise shift until saturated
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {lr_prev, armed, hold_ok, shift, hold, cnt} <= '0;
      {bus.l_chan_o, bus.r_chan_o, bus.valid_o, bus.err_o} <= '0;
    end else begin
      bus.valid_o <= 1'b0;
      bus.err_o <= 1'b0;
      if (ev_p[1]) begin
        if (lr_p[1] != lr_prev) begin
          lr_prev <= lr_p[1];
          cnt <= '0;
          if (!armed) armed <= lr_prev == I2S_CH_RIGHT;
          else if (!full) begin
            bus.err_o <= 1'b1;
            hold_ok <= 1'b0;
          end else if (lr_prev == I2S_CH_LEFT) begin
            hold <= shift;
            hold_ok <= 1'b1;
          end else begin
            hold_ok <= 1'b0;
            if (hold_ok) begin
              bus.l_chan_o <= hold;
              bus.r_chan_o <= shift;
              bus.valid_o <= 1'b1;
            end
          end
        end else if (!full) begin
          shift <= {shift[SAMPLE_BITS-2:0], dat_p[1]};
          cnt <= cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_i2s_decoder.sv
// tb_i2s_decoder: directed I2S frames driven into the receiver with hand-computed pairs
module tb_i2s_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0, miss = 0;
  int vcnt = 0, ecnt = 0, tear = 0, cyc = 0, vt_last = 0, vt_prev = 0;
  logic [15:0] pl = '0, pr = '0;
  i2s_decoder_if #(.SAMPLE_BITS(16)) bus ();
  i2s_decoder #(.SAMPLE_BITS(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #20 clk = ~clk;
  // observe pulses and any output change not accompanied by valid
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.valid_o) begin
      vcnt <= vcnt + 1;
      vt_prev <= vt_last;
      vt_last <= cyc;
    end
    if (bus.err_o) ecnt <= ecnt + 1;
    if (!rst && !bus.valid_o && (bus.l_chan_o != pl || bus.r_chan_o != pr)) tear <= tear + 1;
    pl <= bus.l_chan_o;
    pr <= bus.r_chan_o;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bitc(input logic lr, input logic d);
    bus.bclk_i = 1'b0;
    bus.lrclk_i = lr;
    bus.dacdat_i = d;
    tick(2);
    bus.bclk_i = 1'b1;
    tick(2);
  endtask
  task automatic slot(input logic lr, input logic [15:0] w, input int nbits, input int from, input int upto);
    for (int i = from; i < upto; i++) bitc(lr, (i >= 1 && i <= nbits) ? w[nbits - i] : 1'b0);
  endtask
  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    slot(1'b0, l, 16, 0, 64);
    slot(1'b1, r, 16, 0, 64);
  endtask
  task automatic test_reset;
    bus.lrclk_i = 1'b0;
    bus.bclk_i = 1'b0;
    bus.dacdat_i = 1'b0;
    rst = 1'b1;
    tick(4);
    vecs++; if (bus.l_chan_o !== 16'h0) begin miss++; $display("FAIL reset_l got %h want 0000", bus.l_chan_o); end
    vecs++; if (bus.r_chan_o !== 16'h0) begin miss++; $display("FAIL reset_r got %h want 0000", bus.r_chan_o); end
    vecs++; if (bus.valid_o !== 1'b0) begin miss++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
    vecs++; if (bus.err_o !== 1'b0) begin miss++; $display("FAIL reset_err got %b want 0", bus.err_o); end
    rst = 1'b0;
    tick(2);
  endtask
  task automatic test_loopback;
    int v0 = vcnt, e0 = ecnt;
    repeat (4) frame(16'h0034, 16'h0012);
    vecs++; if (vcnt - v0 !== 2) begin miss++; $display("FAIL loop_valid_count got %0d want 2", vcnt - v0); end
    vecs++; if (vt_last - vt_prev !== 512) begin miss++; $display("FAIL loop_period got %0d want 512", vt_last - vt_prev); end
    vecs++; if (ecnt - e0 !== 0) begin miss++; $display("FAIL loop_err got %0d want 0", ecnt - e0); end
    vecs++; if (bus.l_chan_o !== 16'h0034) begin miss++; $display("FAIL loop_l got %h want 0034", bus.l_chan_o); end
    vecs++; if (bus.r_chan_o !== 16'h0012) begin miss++; $display("FAIL loop_r got %h want 0012", bus.r_chan_o); end
  endtask
  task automatic test_extremes;
    int v0 = vcnt, t0 = tear;
    repeat (2) frame(16'hFFFF, 16'h8000);
    vecs++; if (bus.l_chan_o !== 16'hFFFF) begin miss++; $display("FAIL ext1_l got %h want ffff", bus.l_chan_o); end
    vecs++; if (bus.r_chan_o !== 16'h8000) begin miss++; $display("FAIL ext1_r got %h want 8000", bus.r_chan_o); end
    repeat (2) frame(16'h0001, 16'h7FFE);
    vecs++; if (bus.l_chan_o !== 16'h0001) begin miss++; $display("FAIL ext2_l got %h want 0001", bus.l_chan_o); end
    vecs++; if (bus.r_chan_o !== 16'h7FFE) begin miss++; $display("FAIL ext2_r got %h want 7ffe", bus.r_chan_o); end
    vecs++; if (vcnt - v0 !== 4) begin miss++; $display("FAIL ext_valid_count got %0d want 4", vcnt - v0); end
    vecs++; if (tear - t0 !== 0) begin miss++; $display("FAIL ext_torn got %0d want 0", tear - t0); end
  endtask
  task automatic test_short_word;
    int v0 = vcnt, e0 = ecnt;
    slot(1'b0, 16'h00A5, 8, 0, 9);
    slot(1'b1, 16'h1234, 16, 0, 64);
    frame(16'h5555, 16'hAAAA);
    vecs++; if (ecnt - e0 !== 1) begin miss++; $display("FAIL short_err got %0d want 1", ecnt - e0); end
    vecs++; if (vcnt - v0 !== 1) begin miss++; $display("FAIL short_valid got %0d want 1", vcnt - v0); end
    vecs++; if (bus.l_chan_o !== 16'h0001 || bus.r_chan_o !== 16'h7FFE) begin miss++; $display("FAIL short_hold got %h/%h want 0001/7ffe", bus.l_chan_o, bus.r_chan_o); end
    frame(16'h5555, 16'hAAAA);
    vecs++; if (bus.l_chan_o !== 16'h5555 || bus.r_chan_o !== 16'hAAAA) begin miss++; $display("FAIL short_recover got %h/%h want 5555/aaaa", bus.l_chan_o, bus.r_chan_o); end
  endtask
  task automatic test_reset_mid_word;
    int v0;
    slot(1'b0, 16'h5A5A, 16, 0, 8);
    rst = 1'b1;
    #1;
    vecs++; if (bus.l_chan_o !== 16'h0 || bus.r_chan_o !== 16'h0) begin miss++; $display("FAIL midrst_out got %h/%h want 0000/0000", bus.l_chan_o, bus.r_chan_o); end
    tick(3);
    rst = 1'b0;
    v0 = vcnt;
    slot(1'b0, 16'h5A5A, 16, 8, 64);
    slot(1'b1, 16'h0F0F, 16, 0, 64);
    frame(16'h1111, 16'h2222);
    vecs++; if (vcnt - v0 !== 0) begin miss++; $display("FAIL midrst_early_valid got %0d want 0", vcnt - v0); end
    frame(16'h3333, 16'h4444);
    vecs++; if (vcnt - v0 !== 1) begin miss++; $display("FAIL midrst_valid got %0d want 1", vcnt - v0); end
    vecs++; if (bus.l_chan_o !== 16'h1111 || bus.r_chan_o !== 16'h2222) begin miss++; $display("FAIL midrst_pair got %h/%h want 1111/2222", bus.l_chan_o, bus.r_chan_o); end
  endtask
  task automatic test_stopped;
    int v0 = vcnt, e0 = ecnt;
    bus.bclk_i = 1'b0;
    tick(2000);
    vecs++; if (vcnt - v0 !== 0 || ecnt - e0 !== 0) begin miss++; $display("FAIL stop_pulses got %0d/%0d want 0/0", vcnt - v0, ecnt - e0); end
    vecs++; if (bus.l_chan_o !== 16'h1111 || bus.r_chan_o !== 16'h2222) begin miss++; $display("FAIL stop_hold got %h/%h want 1111/2222", bus.l_chan_o, bus.r_chan_o); end
    frame(16'h5656, 16'h7878);
    vecs++; if (vcnt - v0 !== 1) begin miss++; $display("FAIL restart_valid got %0d want 1", vcnt - v0); end
    vecs++; if (bus.l_chan_o !== 16'h3333 || bus.r_chan_o !== 16'h4444) begin miss++; $display("FAIL restart_pair got %h/%h want 3333/4444", bus.l_chan_o, bus.r_chan_o); end
  endtask
  task automatic test_latency;
    bus.bclk_i = 1'b0;
    bus.lrclk_i = 1'b0;
    bus.dacdat_i = 1'b0;
    tick(2);
    bus.bclk_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vecs++; if (bus.valid_o !== 1'b0) begin miss++; $display("FAIL lat_early edge %0d got %b want 0", i, bus.valid_o); end
    end
    tick(1);
    vecs++; if (bus.valid_o !== 1'b1) begin miss++; $display("FAIL lat_edge4 got %b want 1", bus.valid_o); end
    vecs++; if (bus.l_chan_o !== 16'h5656 || bus.r_chan_o !== 16'h7878) begin miss++; $display("FAIL lat_pair got %h/%h want 5656/7878", bus.l_chan_o, bus.r_chan_o); end
    tick(1);
    vecs++; if (bus.valid_o !== 1'b0) begin miss++; $display("FAIL lat_pulse_width got %b want 0", bus.valid_o); end
    bus.bclk_i = 1'b0;
    tick(2);
  endtask
  initial begin
    test_reset;
    test_loopback;
    test_extremes;
    test_short_word;
    test_reset_mid_word;
    test_stopped;
    test_latency;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
